// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station array: default widths,
// the reserved "operand ready" tag and the entry layout.
package rs_pkg;

    localparam int unsigned RS_SIZE_DEF = 4;
    localparam int unsigned TAG_W_DEF   = 5;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned OP_W_DEF    = 6;
    localparam int unsigned CNT_W_DEF   = 3;

    localparam logic [TAG_W_DEF-1:0] TAG_NONE = '1;

    // Index/age width for an n-deep array; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned AGE_W_DEF = idx_width(RS_SIZE_DEF);

    // Entry layout for the default configuration.
    typedef struct packed {
        logic                  busy;
        logic [OP_W_DEF-1:0]   op;
        logic [DATA_W_DEF-1:0] vj;
        logic [DATA_W_DEF-1:0] vk;
        logic [TAG_W_DEF-1:0]  qj;
        logic [TAG_W_DEF-1:0]  qk;
        logic [TAG_W_DEF-1:0]  dest;
        logic [AGE_W_DEF-1:0]  age;
    } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Combinational compare tree that picks the ready entry with the largest age.
// IDX_W must equal clog2(N); the tree is padded to 2**IDX_W leaves.
module rs_oldest_select
    import rs_pkg::*;
#(
    parameter int unsigned N     = RS_SIZE_DEF,
    parameter int unsigned AGE_W = AGE_W_DEF,
    parameter int unsigned IDX_W = AGE_W_DEF
) (
    input  logic [N-1:0]       ready,
    input  logic [N*AGE_W-1:0] ages,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    localparam int unsigned LEVELS = IDX_W;
    localparam int unsigned LEAVES = 1 << LEVELS;

    logic [LEAVES-1:0]       rdy_pad;
    logic [LEAVES*AGE_W-1:0] age_pad;

    logic [LEAVES-1:0] v  [LEVELS+1];
    logic [AGE_W-1:0]  a  [LEVELS+1][LEAVES];
    logic [IDX_W-1:0]  ix [LEVELS+1][LEAVES];

    assign rdy_pad = LEAVES'(ready);
    assign age_pad = (LEAVES*AGE_W)'(ages);

    always_comb begin
        v  = '{default: '0};
        a  = '{default: '0};
        ix = '{default: '0};
        for (int i = 0; i < int'(LEAVES); i++) begin
            v[0][i]  = rdy_pad[i];
            a[0][i]  = age_pad[i*AGE_W +: AGE_W];
            ix[0][i] = IDX_W'(i);
        end
        // Each node forwards the older valid child; ages are unique so no tie.
        for (int l = 0; l < int'(LEVELS); l++) begin
            for (int i = 0; i < int'(LEAVES / 2); i++) begin
                v[l+1][i] = v[l][2*i] | v[l][2*i+1];
                if (v[l][2*i] && (!v[l][2*i+1] || (a[l][2*i] > a[l][2*i+1]))) begin
                    a[l+1][i]  = a[l][2*i];
                    ix[l+1][i] = ix[l][2*i];
                end else begin
                    a[l+1][i]  = a[l][2*i+1];
                    ix[l+1][i] = ix[l][2*i+1];
                end
            end
        end
        found = v[LEVELS][0];
        idx   = ix[LEVELS][0];
    end

endmodule

// File: rtl/rs_array.sv
// Tomasulo reservation-station array feeding one ALU: oldest-ready-first
// dispatch, CDB snooping with same-cycle capture at issue, and flush.
module rs_array
    import rs_pkg::*;
#(
    parameter int unsigned RS_SIZE = RS_SIZE_DEF,
    parameter int unsigned TAG_W   = TAG_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_en,
    input  logic [OP_W-1:0]   opcode,
    input  logic [TAG_W-1:0]  tag_dest,
    input  logic [TAG_W-1:0]  tag_rs,
    input  logic              rs_ready,
    input  logic [DATA_W-1:0] val_rs,
    input  logic [TAG_W-1:0]  tag_rt,
    input  logic              rt_ready,
    input  logic [DATA_W-1:0] val_rt,
    output logic              stall,
    output logic [CNT_W-1:0]  free_cnt,
    input  logic              alu_ready,
    output logic              alu_valid,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [TAG_W-1:0]  alu_dest_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data
);

    localparam int unsigned IDX_W = idx_width(RS_SIZE);
    localparam int unsigned AGE_W = IDX_W;
    localparam logic [TAG_W-1:0] NONE = '1;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic [TAG_W-1:0]  dest;
        logic [AGE_W-1:0]  age;
    } entry_t;

    entry_t ent [RS_SIZE];

    logic [RS_SIZE-1:0]       ready;
    logic [RS_SIZE*AGE_W-1:0] ages;
    logic                     found;
    logic [IDX_W-1:0]         sel;
    logic [IDX_W-1:0]         slot;
    logic [AGE_W-1:0]         disp_age;
    logic                     do_issue;
    logic                     do_disp;
    logic                     cdb_hit;
    logic [DATA_W-1:0]        new_vj;
    logic [DATA_W-1:0]        new_vk;
    logic [TAG_W-1:0]         new_qj;
    logic [TAG_W-1:0]         new_qk;

    // Occupancy and lowest-index free slot, both from registered busy bits.
    always_comb begin
        free_cnt = '0;
        slot     = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (!ent[i].busy) begin
                free_cnt = free_cnt + CNT_W'(1);
                slot     = IDX_W'(i);
            end
        end
    end

    assign stall = (free_cnt == '0);

    always_comb begin
        ready = '0;
        ages  = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            ready[i]                = ent[i].busy && (ent[i].qj == NONE) && (ent[i].qk == NONE);
            ages[i*AGE_W +: AGE_W]  = ent[i].age;
        end
    end

    rs_oldest_select #(
        .N     (RS_SIZE),
        .AGE_W (AGE_W),
        .IDX_W (IDX_W)
    ) u_select (
        .ready (ready),
        .ages  (ages),
        .found (found),
        .idx   (sel)
    );

    assign do_issue = issue_en && !stall;
    assign do_disp  = alu_ready && found;
    assign cdb_hit  = cdb_valid && (cdb_tag != NONE);
    assign disp_age = ent[sel].age;

    // Operand capture at issue: explicit ready value, then CDB bypass, else wait.
    always_comb begin
        new_vj = val_rs;
        new_qj = NONE;
        if (!rs_ready) begin
            if (cdb_hit && (cdb_tag == tag_rs)) begin
                new_vj = cdb_data;
            end else begin
                new_vj = '0;
                new_qj = tag_rs;
            end
        end
        new_vk = val_rt;
        new_qk = NONE;
        if (!rt_ready) begin
            if (cdb_hit && (cdb_tag == tag_rt)) begin
                new_vk = cdb_data;
            end else begin
                new_vk = '0;
                new_qk = tag_rt;
            end
        end
    end

    // Ages stay a dense 0..n-1 ranking: +1 on issue, -1 when an older-than-us
    // slot... rather, when a younger-than-us entry leaves, so they never overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                ent[i].busy <= 1'b0;
                ent[i].qj   <= NONE;
                ent[i].qk   <= NONE;
                ent[i].age  <= '0;
            end
            alu_valid <= 1'b0;
            if (rst) begin
                alu_opcode   <= '0;
                alu_op1      <= '0;
                alu_op2      <= '0;
                alu_dest_tag <= NONE;
            end
        end else begin
            alu_valid <= do_disp;
            if (do_disp) begin
                alu_opcode   <= ent[sel].op;
                alu_op1      <= ent[sel].vj;
                alu_op2      <= ent[sel].vk;
                alu_dest_tag <= ent[sel].dest;
            end
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (do_issue && (IDX_W'(i) == slot)) begin
                    ent[i].busy <= 1'b1;
                    ent[i].op   <= opcode;
                    ent[i].vj   <= new_vj;
                    ent[i].vk   <= new_vk;
                    ent[i].qj   <= new_qj;
                    ent[i].qk   <= new_qk;
                    ent[i].dest <= tag_dest;
                    ent[i].age  <= '0;
                end else if (ent[i].busy) begin
                    if (do_disp && (IDX_W'(i) == sel)) begin
                        ent[i].busy <= 1'b0;
                    end else begin
                        if (cdb_hit && (ent[i].qj == cdb_tag)) begin
                            ent[i].vj <= cdb_data;
                            ent[i].qj <= NONE;
                        end
                        if (cdb_hit && (ent[i].qk == cdb_tag)) begin
                            ent[i].vk <= cdb_data;
                            ent[i].qk <= NONE;
                        end
                        ent[i].age <= ent[i].age + AGE_W'(do_issue)
                                    - AGE_W'(do_disp && (ent[i].age > disp_age));
                    end
                end
            end
        end
    end

endmodule

// File: doc/rs_array.md
Name: rs_array

Overview:
Parametrised Tomasulo reservation-station array feeding one ALU. It replaces the fixed 2-entry station with an RS_SIZE-deep array that adds:
- oldest-ready-first dispatch
- same-cycle CDB capture at issue
- flush
- a free-entry count

It sits between the issue/rename stage and the ALU, and snoops the common data bus (CDB).

Parameters:
RS_SIZE, 4, number of entries (2..16)
TAG_W, 5, tag width; all-ones value is reserved as NONE ("operand ready")
DATA_W, 32, operand width
OP_W, 6, opcode width
CNT_W, 3, width of free_cnt; must hold RS_SIZE (= clog2(RS_SIZE+1))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries (branch mispredict)
issue_en  in  1  issue request
opcode  in  OP_W  issued opcode
tag_dest  in  TAG_W  destination tag
tag_rs / rs_ready / val_rs  in  TAG_W/1/DATA_W  source 1: producer tag, ready flag, value
tag_rt / rt_ready / val_rt  in  TAG_W/1/DATA_W  source 2: producer tag, ready flag, value
stall  out  1  array full; issue_en is ignored while high
free_cnt  out  CNT_W  number of non-busy entries
alu_ready  in  1  ALU can accept an op this cycle
alu_valid  out  1  registered one-cycle dispatch strobe
alu_opcode / alu_op1 / alu_op2 / alu_dest_tag  out  OP_W/DATA_W/DATA_W/TAG_W  dispatched op
cdb_valid / cdb_tag / cdb_data  in  1/TAG_W/DATA_W  common data bus

Behaviour:
- Entry state: busy, op, Vj, Vk, Qj, Qk, dest, age[clog2(RS_SIZE)-1:0].
- Reset (rst=1 at posedge):
  - all entries cleared: busy=0, Qj=Qk=NONE, age=0.
  - outputs: alu_valid=0, alu_opcode=0, alu_op1=0, alu_op2=0, alu_dest_tag=NONE.
  - stall=0, free_cnt=RS_SIZE on the following cycle.
- Flush: same effect as reset on the entries and on alu_valid. Flush has priority over issue, dispatch and CDB in that cycle.
- stall and free_cnt are combinational from the registered busy bits. stall = (free_cnt==0).
- Issue (issue_en && !stall):
  - target is the lowest-index non-busy entry; it is written at posedge with age=0.
  - every other busy entry increments its age. Ages are unique among busy entries and never overflow.
- Source capture at issue, per source:
  - if *_ready, V=val and Q=NONE.
  - else if cdb_valid && cdb_tag==tag, V=cdb_data and Q=NONE (same-cycle bypass).
  - else Q=tag.
- Ready entry: busy && Qj==NONE && Qk==NONE, evaluated on registered state.
  - A CDB wakeup at cycle t makes the entry eligible at t+1.
- Dispatch (alu_ready and at least one ready entry):
  - select the ready entry with the largest age; ties are impossible.
  - register its fields onto the alu_* outputs, set alu_valid=1 for exactly one cycle, clear busy.
  - alu_valid is 0 otherwise; alu_* data outputs hold their last value.
  - Dispatch latency from ready to alu_valid is 1 cycle.
- Simultaneous issue and dispatch:
  - stall uses pre-edge busy, so an entry freed at posedge is reusable only from the next cycle.
  - the new entry's age increment applies to the surviving entries only.
- CDB wakeup: every busy entry whose Qj (or Qk) equals cdb_tag takes cdb_data and sets Q=NONE.
  - both sources may match in the same cycle.
  - cdb_tag==NONE is ignored.
  - wakeup on the entry being dispatched that cycle is irrelevant, since the entry is freed.
- Issuing with tag_rs==NONE and rs_ready=0 is illegal; the verification engineer asserts against it.

Decomposition:
- Shared package rs_pkg: TAG_NONE = {TAG_W{1'b1}}, default widths, and an entry-struct typedef (Verilog users: an rs_defs.vh include).
- Sub-module rs_oldest_select: purely combinational.
  - inputs: ready vector and packed age vector.
  - outputs: found flag and index.
  - implemented as a parametrised compare tree.
- Free-slot finder stays inline as a priority encoder.

Test Plan:
1. Reset, then issue 4 ready ops (tags 1-4) with alu_ready=0 → stall=1 and free_cnt=0 after the 4th; a 5th issue_en is ignored. Raise alu_ready → alu_dest_tag order is 1,2,3,4 on 4 consecutive alu_valid pulses.
2. Issue tag 1 waiting on Qj=7, then tag 2 fully ready; alu_ready=1 → tag 2 dispatches first. CDB(tag=7, data=0xDEAD) → tag 1 dispatches 2 cycles later with alu_op1=0xDEAD.
3. Issue with rs_ready=0, tag_rs=9 while cdb_valid, cdb_tag=9, data=0x55 in the same cycle → entry captures 0x55 and dispatches at the next cycle, with no hang.
4. Entry waiting on Qj=3 and Qk=3; CDB tag 3, data 0xA → alu_op1=alu_op2=0xA.
5. Full array, then dispatch and issue in the same cycle → stall drops for one cycle and the new entry is accepted the next cycle. The new entry dispatches after all older ready entries.
6. Three busy entries, then flush=1 concurrent with issue_en and cdb_valid → free_cnt=RS_SIZE next cycle and alu_valid=0. Repeat with rst=1 mid-dispatch → identical result.
